// File: rtl/num2str.sv
// num2str: sequential number-to-ASCII formatter.
//
// Converts a 32-bit unsigned value into a null-terminated ASCII stream:
// one radix prefix character ('D', 'B' or 'H'), the digits most-significant
// first, then 8'h00. One character is produced per clock.
//
// Optional build macro: NUM2STR_STALL_EN adds the Ack input so the sink can
// stall the stream. Without it the sink must take one character per cycle.
//
// Handshake: Start is honoured only at a rising edge where Ready=1. Each
// character is presented with Valid=1 on str. With NUM2STR_STALL_EN, a
// character is consumed at a rising edge where Valid=1 and Ack=1, otherwise
// str/Valid hold. Ack is ignored while Valid=0. str is 8'h00 whenever Valid=0.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   asynchronous active-high reset
//   num       in   value to convert, sampled on an accepted Start
//   radix     in   00/11 decimal, 01 binary, 10 hex, sampled with num
//   Start     in   conversion request
//   str       out  ASCII character
//   Valid     out  str carries a character this cycle
//   dbg_state out  current FSM state encoding
//   Ready     out  idle, will accept Start
//   Ack       in   sink accepts str (NUM2STR_STALL_EN builds only)
module num2str #(
    parameter int DIG_DEPTH = 32
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] num,
    input  logic [1:0]  radix,
    input  logic        Start,
    output logic [7:0]  str,
    output logic        Valid,
    output logic [2:0]  dbg_state,
    output logic        Ready
`ifdef NUM2STR_STALL_EN
    ,
    input  logic        Ack
`endif
);

    localparam int CW = $clog2(DIG_DEPTH + 1);
    localparam int AW = $clog2(DIG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONV     = 3'd1,
        S_DIV      = 3'd2,
        S_EMIT_PFX = 3'd3,
        S_EMIT_DIG = 3'd4,
        S_EMIT_NUL = 3'd5
    } state_t;

    state_t        state;
    logic [31:0]   q;        // work value; holds the running quotient in DIV
    logic [1:0]    r;        // latched radix
    logic [CW-1:0] cnt;      // digits stored in digbuf
    logic [4:0]    step;     // division step 0..31
    logic [3:0]    rem;      // partial remainder, always < 10
    logic [3:0]    digbuf [DIG_DEPTH];

    logic          advance;
    logic          is_dec;
    logic          is_hex;
    logic [7:0]    pfx_char;
    logic [7:0]    rd_char;
    logic [31:0]   q_shr;
    logic [3:0]    shr_dig;
    logic [4:0]    rem_sh;
    logic          rem_ge;
    logic [3:0]    rem_nx;
    logic [31:0]   q_div_nx;
    logic          push_en;
    logic [3:0]    push_dig;

`ifdef NUM2STR_STALL_EN
    assign advance = Ack;
`else
    assign advance = 1'b1;
`endif

    assign dbg_state = state;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d < 4'd10) return 8'h30 + {4'h0, d};
        else           return 8'h37 + {4'h0, d};
    endfunction

    always_comb begin
        is_dec   = (r == 2'b00) || (r == 2'b11);
        is_hex   = (r == 2'b10);
        pfx_char = is_dec ? 8'h44 : (is_hex ? 8'h48 : 8'h42);

        // Binary/hex: peel the low digit and shift it out.
        q_shr    = is_hex ? {4'h0, q[31:4]} : {1'b0, q[31:1]};
        shr_dig  = is_hex ? q[3:0] : {3'b000, q[0]};

        // One restoring-division step by 10: bring in the next dividend bit
        // (MSB of q), subtract 10 if it fits, shift the quotient bit into q.
        rem_sh   = {rem, q[31]};
        rem_ge   = (rem_sh >= 5'd10);
        rem_nx   = rem_ge ? 4'(rem_sh - 5'd10) : rem_sh[3:0];
        q_div_nx = {q[30:0], rem_ge};

        push_en  = ((state == S_CONV) && !is_dec) ||
                   ((state == S_DIV) && (step == 5'd31));
        push_dig = (state == S_DIV) ? rem_nx : shr_dig;

        // Digits come out in reverse order of production.
        rd_char  = to_ascii(digbuf[AW'(cnt - 1'b1)]);
    end

    // Digit storage needs no reset: cnt says which entries are meaningful.
    always_ff @(posedge Clk) begin
        if (push_en) digbuf[AW'(cnt)] <= push_dig;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
            Ready <= 1'b1;
            Valid <= 1'b0;
            str   <= 8'h00;
            cnt   <= '0;
            q     <= '0;
            r     <= 2'b00;
            step  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        q     <= num;
                        r     <= radix;
                        cnt   <= '0;
                        Ready <= 1'b0;
                        state <= S_CONV;
                    end
                end

                S_CONV: begin
                    if (is_dec) begin
                        step  <= '0;
                        rem   <= '0;
                        state <= S_DIV;
                    end else begin
                        q   <= q_shr;
                        cnt <= cnt + 1'b1;
                        if (q_shr == 32'd0) begin
                            Valid <= 1'b1;
                            str   <= pfx_char;
                            state <= S_EMIT_PFX;
                        end
                    end
                end

                S_DIV: begin
                    q <= q_div_nx;
                    if (step == 5'd31) begin
                        // Remainder of this pass is the next digit; q now
                        // holds the quotient for the following pass.
                        cnt  <= cnt + 1'b1;
                        step <= '0;
                        rem  <= '0;
                        if (q_div_nx == 32'd0) begin
                            Valid <= 1'b1;
                            str   <= pfx_char;
                            state <= S_EMIT_PFX;
                        end
                    end else begin
                        step <= step + 5'd1;
                        rem  <= rem_nx;
                    end
                end

                S_EMIT_PFX: begin
                    if (advance) begin
                        str   <= rd_char;
                        cnt   <= cnt - 1'b1;
                        state <= S_EMIT_DIG;
                    end
                end

                S_EMIT_DIG: begin
                    if (advance) begin
                        if (cnt == '0) begin
                            str   <= 8'h00;
                            state <= S_EMIT_NUL;
                        end else begin
                            str <= rd_char;
                            cnt <= cnt - 1'b1;
                        end
                    end
                end

                S_EMIT_NUL: begin
                    if (advance) begin
                        Valid <= 1'b0;
                        str   <= 8'h00;
                        Ready <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    Valid <= 1'b0;
                    str   <= 8'h00;
                    Ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/num2str.md
Name: num2str

Overview:
- Sequential number-to-ASCII formatter; the transmit-side counterpart of the string-to-number parser.
- Takes a 32-bit unsigned value and a radix, then emits a null-terminated ASCII character stream, one character per clock.
- Stream format is prefix char, digits MS-first, then 8'h00, so the parser's input format round-trips exactly.
- Sits between the MiniComputer datapath and any character sink (display or serial buffer).

Parameters:
- DIG_DEPTH, 32, digit buffer entries (max digits, reached by binary radix).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- num  input  32  unsigned value; sampled when the conversion starts.
- radix  input  2  00=decimal 'D', 01=binary 'B', 10=hex 'H', 11=decimal; sampled with num.
- Start  input  1  request pulse; honoured only while Ready=1.
- str  output  8  ASCII character out.
- Valid  output  1  str holds a character this cycle.
- Ready  output  1  idle, accepts Start.
- Ack  input  1  sink accepts str (present only with NUM2STR_STALL_EN).

Behaviour:
- Reset (async, any state): state=IDLE, Ready=1, Valid=0, str=8'h00, digit count=0, buffer contents don't-care. Reset mid-stream aborts immediately; no terminator is sent.
- FSM states: IDLE, CONV, DIV, EMIT_PFX, EMIT_DIG, EMIT_NUL.
- IDLE: Ready=1, Valid=0. On Start=1 at a rising edge:
  - latch num into work register Q and radix into R;
  - clear count; Ready=0 from the next cycle;
  - go to CONV.
  - Start while Ready=0 is ignored.
- CONV, binary or hex:
  - Each cycle, push digit Q[0] (binary) or Q[3:0] (hex) into buffer[count].
  - Q shifts right by 1 or 4; count increments.
  - If the new Q is 0, go to EMIT_PFX.
  - At least one digit is always pushed, so num=0 gives "0".
- CONV, decimal:
  - Enter DIV: 32-step restoring division of Q by 10, one quotient bit per cycle, using a 4-bit remainder extended to 5 bits.
  - After step 32, the remainder is pushed as a digit and Q becomes the quotient.
  - Return to DIV if quotient≠0, else go to EMIT_PFX.
  - Max 10 digits, i.e. ≤ 330 cycles.
- No division or multiply operators on 32-bit operands; use subtract/compare only.
- EMIT_PFX: Valid=1, str = 8'h44 / 8'h42 / 8'h48 per R.
- EMIT_DIG: str = ASCII of buffer[count-1]:
  - 0-9 map to 8'h30-8'h39;
  - 10-15 map to 8'h41-8'h46 (uppercase);
  - decrement count each emitted char; after count reaches 0, go to EMIT_NUL.
- EMIT_NUL: Valid=1, str=8'h00; next cycle IDLE with Ready=1.
- Stream is contiguous: prefix, digits, terminator on consecutive cycles with Valid=1. Valid=0 everywhere else, and str=8'h00 whenever Valid=0.
- No leading zeros except the single '0' for num=0.
- Stream length = 2 + digit count.

Optional Feature:
- NUM2STR_STALL_EN defined:
  - Ack port exists.
  - In the EMIT_* states, str and Valid hold and the FSM does not advance unless Ack=1 at the edge.
  - Ack has no effect while Valid=0.
- Undefined:
  - No Ack port; the sink must take one char per cycle, exactly as described in Behaviour.

Test Plan:
- Reset mid-conversion (Rst pulse during DIV) -> Ready=1, Valid=0, str=00 immediately (async); a new Start works normally.
- num=561, radix=00, Start -> Valid stream 44,35,36,31,00 on consecutive cycles; Ready=1 the cycle after 00.
- num=6, radix=01 -> 42,31,31,30,00; num=30, radix=10 -> 48,31,45,00.
- num=0, radix=00 -> 44,30,00.
- num=32'hFFFFFFFF:
  - radix=00 -> 44 then "4294967295" then 00, conversion ≤ 330 cycles;
  - radix=01 -> 42, 32×31, 00.
- Start held high during emission -> ignored.
- radix=11 -> same output as 00.
- With NUM2STR_STALL_EN: Ack=0 for 3 cycles mid-digits -> str/Valid held unchanged, no char lost or duplicated.
- Loopback: num2str output into the parser -> recovered value equals the original for radix 00/01/10.
